// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin front end for a single bram_with_ack
// 128-bit memory. Each granted access runs as IDLE -> ISSUE -> WAIT -> RESP,
// so only one memory access is ever outstanding.
// Optional WAIT timeout: define BRAM_ARBITER_TIMEOUT_EN.
module bram_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  // requester 0
  input  logic                  req0_cs,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [127:0]          req0_block_wr,
  output logic                  req0_ack,
  output logic [127:0]          req0_block_rd,
  output logic                  req0_error,
  // requester 1
  input  logic                  req1_cs,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [127:0]          req1_block_wr,
  output logic                  req1_ack,
  output logic [127:0]          req1_block_rd,
  output logic                  req1_error,
  // memory side, 1:1 with the BRAM ports
  output logic                  mem_cs,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [127:0]          mem_block_wr,
  input  logic [127:0]          mem_block_rd,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;   // requester owning the current access
  logic                  last_q,  last_d;    // requester granted most recently
  logic                  we_q,    we_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [127:0]          wr_q,    wr_d;
  logic [127:0]          rd0_q,   rd0_d;
  logic [127:0]          rd1_q,   rd1_d;

`ifdef BRAM_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // State and datapath registers; reset returns everything to idle zeros.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifdef BRAM_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifdef BRAM_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next state: arbitrate and latch in IDLE, one-cycle issue, wait for ack, respond.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifdef BRAM_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_cs || req1_cs) begin
          // lone requester wins; on contention the one not served last wins
          grant_d = (req0_cs && req1_cs) ? ~last_q : req1_cs;
          we_d    = grant_d ? req1_we       : req0_we;
          addr_d  = grant_d ? req1_addr     : req0_addr;
          wr_d    = grant_d ? req1_block_wr : req0_block_wr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef BRAM_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
      end
      WAIT: begin
        if (mem_ack) begin
          if (grant_q) rd1_d = mem_block_rd;
          else         rd0_d = mem_block_rd;
          state_d = RESP;
        end
`ifdef BRAM_ARBITER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // give up: report zero data with an error flag
          if (grant_q) rd1_d = '0;
          else         rd0_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        // the following IDLE cycle lets the requester drop or renew cs
        last_d  = grant_q;
        state_d = IDLE;
`ifdef BRAM_ARBITER_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registers, so they are zero out of reset.
  assign mem_cs        = (state_q == ISSUE);
  assign mem_we        = mem_cs & we_q;
  assign mem_addr      = addr_q;
  assign mem_block_wr  = wr_q;
  assign busy          = (state_q != IDLE);
  assign req0_ack      = (state_q == RESP) & ~grant_q;
  assign req1_ack      = (state_q == RESP) &  grant_q;
  assign req0_block_rd = rd0_q;
  assign req1_block_rd = rd1_q;
`ifdef BRAM_ARBITER_TIMEOUT_EN
  assign req0_error    = req0_ack & err_q;
  assign req1_error    = req1_ack & err_q;
`else
  assign req0_error    = 1'b0;
  assign req1_error    = 1'b0;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: randomized bench for bram_arbiter. A BRAM model answers the
// memory side; a timeline reference model (grant cycle + fixed offsets, plain
// memory array) predicts every output each cycle.
module tb_bram_arbiter;
  localparam int AW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          req0_cs = 1'b0, req1_cs = 1'b0, req0_we = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [127:0]  req0_block_wr = '0, req1_block_wr = '0;
  logic          req0_ack, req1_ack, req0_error, req1_error;
  logic [127:0]  req0_block_rd, req1_block_rd;
  logic          mem_cs, mem_we, busy;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_block_wr;
  logic [127:0]  mem_block_rd = '0;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .areset(areset),
    .req0_cs(req0_cs), .req0_we(req0_we), .req0_addr(req0_addr), .req0_block_wr(req0_block_wr),
    .req0_ack(req0_ack), .req0_block_rd(req0_block_rd), .req0_error(req0_error),
    .req1_cs(req1_cs), .req1_we(req1_we), .req1_addr(req1_addr), .req1_block_wr(req1_block_wr),
    .req1_ack(req1_ack), .req1_block_rd(req1_block_rd), .req1_error(req1_error),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_block_wr(mem_block_wr), .mem_block_rd(mem_block_rd), .busy(busy)
  );

  function automatic logic [127:0] init_word(input int i);
    return {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  // BRAM: ack one cycle after cs, read-before-write, contents survive reset
  logic [127:0] bmem [16];
  logic         binit = 1'b0;
  logic         noack = 1'b0;
  always @(posedge clk) begin
    if (!binit) begin
      for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
      binit <= 1'b1;
    end else if (mem_cs) begin
      mem_block_rd <= bmem[mem_addr];
      if (mem_we) bmem[mem_addr] <= mem_block_wr;
    end
    mem_ack <= areset ? 1'b0 : (mem_cs & ~noack);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: an access granted in cycle g shows mem_cs at g+1,
  // ack + data at g+3, and the arbiter is free again at g+4
  logic [127:0]  rmem [16];
  logic [127:0]  m_rd [2];
  logic [127:0]  m_lwr, m_data;
  logic [AW-1:0] m_laddr;
  bit            m_valid = 0, m_en = 1, m_pend = 0, m_win = 0, m_last = 1, m_lwe = 0;
  int            mc = 0, m_gt = 0;

  task automatic model_step();
    bit ea0, ea1, ecs;
    if (m_en && m_valid) begin
      ea0 = 0; ea1 = 0;
      if (m_pend && mc == m_gt + 3) begin
        m_rd[m_win] = m_data;
        if (m_win) ea1 = 1; else ea0 = 1;
      end
      ecs = m_pend && mc == m_gt + 1;
      chk("ack0", req0_ack, ea0);
      chk("ack1", req1_ack, ea1);
      chk("rd0", req0_block_rd, m_rd[0]);
      chk("rd1", req1_block_rd, m_rd[1]);
      chk("err0", req0_error, 0);
      chk("err1", req1_error, 0);
      chk("mem_cs", mem_cs, ecs);
      chk("mem_we", mem_we, ecs & m_lwe);
      chk("mem_addr", mem_addr, m_laddr);
      chk("mem_wr", mem_block_wr, m_lwr);
      chk("busy", busy, m_pend);
    end
    if (areset) begin
      if (!m_valid) for (int i = 0; i < 16; i++) rmem[i] = init_word(i);
      m_valid = 1; m_pend = 0; m_last = 1; m_lwe = 0; m_laddr = '0; m_lwr = '0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else if (m_pend) begin
      if (mc == m_gt + 3) begin m_pend = 0; m_last = m_win; end
    end else if (req0_cs || req1_cs) begin
      m_win   = (req0_cs && req1_cs) ? ~m_last : req1_cs;
      m_gt    = mc;
      m_pend  = 1;
      m_lwe   = m_win ? req1_we : req0_we;
      m_laddr = m_win ? req1_addr : req0_addr;
      m_lwr   = m_win ? req1_block_wr : req0_block_wr;
      m_data  = rmem[m_laddr];
      if (m_lwe) rmem[m_laddr] = m_lwr;
    end
    mc++;
  endtask

  // one clock: model + sample at negedge, then requesters drop cs after ack/reset
  bit a0, a1, e0;
  logic [127:0] r0, r1;
  task automatic tick();
    @(negedge clk);
    model_step();
    a0 = req0_ack; a1 = req1_ack; e0 = req0_error;
    if (a0) r0 = req0_block_rd;
    if (a1) r1 = req1_block_rd;
    @(posedge clk); #1;
    if (a0 || areset) req0_cs = 1'b0;
    if (a1 || areset) req1_cs = 1'b0;
  endtask

  task automatic req(input int p, input bit we, input logic [AW-1:0] a, input logic [127:0] d);
    if (p == 0) begin req0_cs = 1; req0_we = we; req0_addr = a; req0_block_wr = d; end
    else        begin req1_cs = 1; req1_we = we; req1_addr = a; req1_block_wr = d; end
  endtask

  task automatic rnd_req(input int p);
    req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
        {$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  // cycles from call until the port's ack, -1 if it never came
  task automatic wait_ack(input int p, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (p == 0 ? a0 : a1) begin lat = n; break; end
    end
    chk(p == 0 ? "ack0_seen" : "ack1_seen", lat >= 0, 1);
  endtask

  // both ports request together; returns each port's ack latency
  task automatic pair(input logic [AW-1:0] ad0, input logic [AW-1:0] ad1, output int l0, output int l1);
    l0 = -1; l1 = -1;
    req(0, 0, ad0, '0); req(1, 0, ad1, '0);
    for (int n = 0; n < 40 && (l0 < 0 || l1 < 0); n++) begin
      tick();
      if (a0) l0 = n;
      if (a1) l1 = n;
    end
  endtask

  initial begin
    int lat, l0, l1, nack;
    int qp[$], qt[$];

    // reset
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rd0", req0_block_rd, 0);
    areset = 0;

    // req0 writes A5.. to addr 3, then reads it back
    req(0, 1, 4'd3, {16{8'hA5}});
    tick();
    chk("iss_cs", mem_cs, 1);
    chk("iss_we", mem_we, 1);
    chk("iss_addr", mem_addr, 3);
    wait_ack(0, lat);
    chk("wr_lat", lat, 2);          // already one cycle past T
    req(0, 0, 4'd3, '0);
    wait_ack(0, lat);
    chk("rd_lat", lat, 3);
    chk("rd_a5", r0, {16{8'hA5}});

    // fresh contention: req0 first, req1 four cycles later
    areset = 1; tick(); areset = 0;
    pair(4'd1, 4'd2, l0, l1);
    chk("ct_lat0", l0, 3);
    chk("ct_lat1", l1, 7);
    chk("ct_d0", r0, init_word(1));
    chk("ct_d1", r1, init_word(2));

    // write returns pre-write contents
    req(1, 1, 4'd5, 128'h7);  wait_ack(1, lat);
    req(1, 1, 4'd5, 128'h1);  wait_ack(1, lat);
    chk("wr_old", r1, 128'h7);
    req(1, 0, 4'd5, '0);      wait_ack(1, lat);
    chk("wr_new", r1, 128'h1);

    // reset while in WAIT
    req(0, 0, 4'd6, '0);
    tick(); tick();
    chk("w_busy", busy, 1);
    chk("w_cs", mem_cs, 0);
    areset = 1; tick(); areset = 0;
    chk("ar_busy", busy, 0);
    chk("ar_cs", mem_cs | mem_we | req0_ack | req1_ack | req0_error | req1_error, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_wr", mem_block_wr, 0);
    chk("ar_rd", req0_block_rd | req1_block_rd, 0);
    nack = 0;
    for (int i = 0; i < 6; i++) begin tick(); nack += int'(a0) + int'(a1); end
    chk("ar_noack", nack, 0);
    pair(4'd7, 4'd8, l0, l1);
    chk("ar_first0", l0 < l1, 1);

    // both requesters stream for 40 cycles: strict alternation, 4-cycle spacing
    rnd_req(0); rnd_req(1);
    for (int c = 0; c < 52; c++) begin
      tick();
      if (a0) begin qp.push_back(0); qt.push_back(c); end
      if (a1) begin qp.push_back(1); qt.push_back(c); end
      if (c < 40) begin
        if (!req0_cs) rnd_req(0);
        if (!req1_cs) rnd_req(1);
      end
    end
    chk("st_n", qp.size() >= 10, 1);
    for (int i = 1; i < qp.size(); i++) begin
      chk("st_alt", qp[i] != qp[i-1], 1);
      chk("st_gap", qt[i] - qt[i-1], 4);
    end

    // random traffic with idle gaps and occasional reset
    for (int c = 0; c < 600; c++) begin
      tick();
      areset = 0;
      if (!req0_cs && $urandom_range(0, 2) == 0) rnd_req(0);
      if (!req1_cs && $urandom_range(0, 2) == 0) rnd_req(1);
      if ($urandom_range(0, 79) == 0) areset = 1;
    end
    areset = 0;
    for (int c = 0; c < 8; c++) tick();

`ifdef BRAM_ARBITER_TIMEOUT_EN
    // no memory ack: abort after TO WAIT cycles with error and zero data
    areset = 1; tick(); areset = 0;
    m_en = 0; noack = 1;
    req(0, 0, 4'd3, '0);
    wait_ack(0, lat);
    chk("to_lat", lat, TO + 2);     // ISSUE at T+1, then TO WAIT cycles
    chk("to_err", e0, 1);
    chk("to_rd", r0, 0);
    chk("to_idle", busy, 0);
    noack = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
